// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state encoding and sizing helper for the sequential magnitude comparator
package cmp_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/cmp_digit.sv
// cmp_digit: combinational DIGIT-bit unsigned slice comparator, equality implied when gt and lt are both low
module cmp_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             lt
);
  assign gt = x > y;
  assign lt = x < y;
endmodule

// File: rtl/cmp_seq_magnitude.sv
// cmp_seq_magnitude: MSB-first slice-serial magnitude comparator with early exit and held one-hot result
module cmp_seq_magnitude
  import cmp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIGIT     = 2,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             less,
  output logic             greater
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, flip;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             eq_q, eq_d, less_q, less_d, greater_q, greater_d;
  logic             s_gt, s_lt, last;
  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .x (sa_q[WIDTH-1 -: DIGIT]),
    .y (sb_q[WIDTH-1 -: DIGIT]),
    .gt(s_gt),
    .lt(s_lt)
  );
  // offset-binary: flipping both MSBs makes unsigned slice order match two's-complement order
  assign flip = {(SIGNED_EN != 0) && is_signed, {(WIDTH-1){1'b0}}};
  assign last = cnt_q == CW'(NDIG - 1);
  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    eq_d      = eq_q;
    less_d    = less_q;
    greater_d = greater_q;
    case (state_q)
      IDLE: if (start) begin
        sa_d    = a ^ flip;
        sb_d    = b ^ flip;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = RUN;
      end
      RUN: if (s_gt || s_lt || last) begin
        greater_d = s_gt;
        less_d    = s_lt;
        eq_d      = !(s_gt || s_lt);
        busy_d    = 1'b0;
        done_d    = 1'b1;
        state_d   = DONE;
      end else begin
        sa_d  = sa_q << DIGIT;
        sb_d  = sb_q << DIGIT;
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      less_q    <= 1'b0;
      greater_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      eq_q      <= eq_d;
      less_q    <= less_d;
      greater_q <= greater_d;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign eq      = eq_q;
  assign less    = less_q;
  assign greater = greater_q;
endmodule
